// File: rtl/cam_pkg.sv
// Shared widths, FSM state encoding and response record for the CAM lookup controller.
package cam_pkg;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SRCH,
        WAIT,
        WR,
        RESP
    } cam_ctrl_state_e;

    typedef struct packed {
        logic             hit;
        logic             full;
        logic [IDX_W-1:0] index;
    } cam_rsp_t;
endpackage

// File: rtl/cam_lookup_ctrl_if.sv
// Client-side request/response handshake of the CAM lookup controller.
interface cam_lookup_ctrl_if;
    import cam_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [DATA_W-1:0] req_data_i;
    logic              req_insert_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_hit_o;
    logic [IDX_W-1:0]  rsp_index_o;
    logic              rsp_full_o;

    modport master (
        output req_valid_i, req_data_i, req_insert_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_full_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_insert_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_full_o
    );
endinterface

// File: rtl/cam_alloc_ptr.sv
// Round-robin allocation pointer plus saturating fill count for the CAM rows.
module cam_alloc_ptr
    import cam_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance,
    output logic [IDX_W-1:0] alloc_ptr,
    output logic [IDX_W:0]   fill_cnt,
    output logic             full
);
    logic [IDX_W-1:0] alloc_ptr_reg;
    logic [IDX_W:0]   fill_cnt_reg;

    assign full      = (fill_cnt_reg == (IDX_W+1)'(DEPTH));
    assign alloc_ptr = alloc_ptr_reg;
    assign fill_cnt  = fill_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_ptr_reg <= '0;
            fill_cnt_reg  <= '0;
        end else if (advance) begin
            alloc_ptr_reg <= (alloc_ptr_reg == IDX_W'(DEPTH-1)) ? '0
                                                                 : alloc_ptr_reg + IDX_W'(1);
            // Once full, replacement writes keep the count pinned at DEPTH.
            if (!full)
                fill_cnt_reg <= fill_cnt_reg + (IDX_W+1)'(1);
        end
    end
endmodule

// File: rtl/cam_lookup_ctrl.sv
// Sequences CAM search/write for lookup and insert requests.
// Define CAM_LOOKUP_REPLACE_EN to overwrite the oldest row on an insert miss when full.
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int SEARCH_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cam_lookup_ctrl_if.slave    req_if,
    output logic                cam_write_enable_o,
    output logic [IDX_W-1:0]    cam_write_index_o,
    output logic [DATA_W-1:0]   cam_write_data_o,
    output logic                cam_search_enable_o,
    output logic [DATA_W-1:0]   cam_search_data_o,
    input  logic                cam_search_valid_i,
    input  logic [IDX_W-1:0]    cam_search_index_i
);
    localparam int WAIT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

    cam_ctrl_state_e   state_reg, state_next;
    logic [DATA_W-1:0] key_reg;
    logic              insert_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    cam_rsp_t          rsp_reg;
    logic              wait_last;
    logic              advance;
    logic [IDX_W-1:0]  alloc_ptr;
    logic [IDX_W:0]    fill_cnt;
    logic              full;

    assign wait_last = (wait_cnt_reg == WAIT_W'(SEARCH_LAT-1));
    assign advance   = (state_reg == WR);

    cam_alloc_ptr u_alloc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance   (advance),
        .alloc_ptr (alloc_ptr),
        .fill_cnt  (fill_cnt),
        .full      (full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req_if.req_valid_i) state_next = SRCH;
            SRCH: state_next = WAIT;
            WAIT: begin
                if (wait_last) begin
                    if (cam_search_valid_i || !insert_reg)
                        state_next = RESP;
                    else if (!full)
                        state_next = WR;
                    else
`ifdef CAM_LOOKUP_REPLACE_EN
                        state_next = WR;
`else
                        state_next = RESP;
`endif
                end
            end
            WR:      state_next = RESP;
            RESP:    if (req_if.rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_if.req_ready_o  = (state_reg == IDLE);
        req_if.rsp_valid_o  = (state_reg == RESP);
        req_if.rsp_hit_o    = rsp_reg.hit;
        req_if.rsp_full_o   = rsp_reg.full;
        req_if.rsp_index_o  = rsp_reg.index;
        cam_search_enable_o = (state_reg == SRCH);
        cam_search_data_o   = (state_reg == SRCH || state_reg == WAIT) ? key_reg : '0;
        cam_write_enable_o  = (state_reg == WR);
        cam_write_index_o   = (state_reg == WR) ? alloc_ptr : '0;
        cam_write_data_o    = (state_reg == WR) ? key_reg : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_reg      <= '0;
            insert_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            rsp_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_if.req_valid_i) begin
                        key_reg    <= req_if.req_data_i;
                        insert_reg <= req_if.req_insert_i;
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_last ? '0 : wait_cnt_reg + WAIT_W'(1);
                    if (wait_last) begin
                        rsp_reg <= '0;
                        if (cam_search_valid_i) begin
                            rsp_reg.hit   <= 1'b1;
                            rsp_reg.index <= cam_search_index_i;
                        end
`ifndef CAM_LOOKUP_REPLACE_EN
                        else if (insert_reg && full)
                            rsp_reg.full <= 1'b1;
`endif
                    end
                end
                // Report the row being written, i.e. the pointer before it advances.
                WR:      rsp_reg.index <= alloc_ptr;
                default: ;
            endcase
        end
    end

    logic unused_fill;
    assign unused_fill = ^fill_cnt;
endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed bench for cam_lookup_ctrl with a behavioural single-latency CAM.
module tb_cam_lookup_ctrl;
    import cam_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cam_write_enable;
    logic [IDX_W-1:0]  cam_write_index;
    logic [DATA_W-1:0] cam_write_data;
    logic              cam_search_enable;
    logic [DATA_W-1:0] cam_search_data;
    logic              cam_search_valid;
    logic [IDX_W-1:0]  cam_search_index;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [IDX_W-1:0] last_wr_idx = '0;

    cam_lookup_ctrl_if req_if ();

    cam_lookup_ctrl #(.SEARCH_LAT(1)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_if              (req_if),
        .cam_write_enable_o  (cam_write_enable),
        .cam_write_index_o   (cam_write_index),
        .cam_write_data_o    (cam_write_data),
        .cam_search_enable_o (cam_search_enable),
        .cam_search_data_o   (cam_search_data),
        .cam_search_valid_i  (cam_search_valid),
        .cam_search_index_i  (cam_search_index)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: result registered one cycle after the search strobe.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vld              <= '0;
            cam_search_valid <= 1'b0;
            cam_search_index <= '0;
        end else begin
            if (cam_search_enable) begin
                cam_search_valid <= 1'b0;
                cam_search_index <= '0;
                for (int i = DEPTH-1; i >= 0; i--) begin
                    if (vld[i] && mem[i] == cam_search_data) begin
                        cam_search_valid <= 1'b1;
                        cam_search_index <= i[IDX_W-1:0];
                    end
                end
            end
            if (cam_write_enable) begin
                mem[cam_write_index] <= cam_write_data;
                vld[cam_write_index] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cam_write_enable) begin
            wr_cnt      = wr_cnt + 1;
            last_wr_idx = cam_write_index;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input string nm, input logic [31:0] data, input logic ins,
                           input logic e_hit, input logic [IDX_W-1:0] e_idx, input logic e_full,
                           input logic e_wr, input int e_lat, input int hold);
        int lat;
        int w0;
        logic h_hit, h_full, stable, busy;
        logic [IDX_W-1:0] h_idx;
        w0 = wr_cnt;
        @(posedge clk); #1;
        req_if.req_valid_i  = 1'b1;
        req_if.req_data_i   = data;
        req_if.req_insert_i = ins;
        req_if.rsp_ready_i  = (hold == 0);
        @(posedge clk); #1;
        req_if.req_valid_i  = 1'b0;
        lat = 1;
        while (!req_if.rsp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " rsp_valid"}, {31'd0, req_if.rsp_valid_o}, 32'd1);
        if (!req_if.rsp_valid_o) begin
            req_if.rsp_ready_i = 1'b1;
            return;
        end
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " hit"}, {31'd0, req_if.rsp_hit_o}, {31'd0, e_hit});
        chk({nm, " index"}, {27'd0, req_if.rsp_index_o}, {27'd0, e_idx});
        chk({nm, " full"}, {31'd0, req_if.rsp_full_o}, {31'd0, e_full});
        chk({nm, " writes"}, wr_cnt - w0, {31'd0, e_wr});
        if (e_wr)
            chk({nm, " write_idx"}, {27'd0, last_wr_idx}, {27'd0, e_idx});
        $display("txn %s key=%h ins=%b hit=%b idx=%0d full=%b writes=%0d lat=%0d",
                 nm, data, ins, req_if.rsp_hit_o, req_if.rsp_index_o, req_if.rsp_full_o,
                 wr_cnt - w0, lat);
        if (hold > 0) begin
            h_hit = req_if.rsp_hit_o; h_idx = req_if.rsp_index_o; h_full = req_if.rsp_full_o;
            stable = 1'b1; busy = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!req_if.rsp_valid_o || req_if.rsp_hit_o !== h_hit ||
                    req_if.rsp_index_o !== h_idx || req_if.rsp_full_o !== h_full)
                    stable = 1'b0;
                if (req_if.req_ready_o !== 1'b0)
                    busy = 1'b0;
            end
            chk({nm, " rsp_stable"}, {31'd0, stable}, 32'd1);
            chk({nm, " ready_low"}, {31'd0, busy}, 32'd1);
            req_if.rsp_ready_i = 1'b1;
        end
        @(posedge clk); #1;
        chk({nm, " ready_after"}, {31'd0, req_if.req_ready_o}, 32'd1);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " req_ready"}, {31'd0, req_if.req_ready_o}, 32'd1);
        chk({nm, " rsp_valid"}, {31'd0, req_if.rsp_valid_o}, 32'd0);
        chk({nm, " wr_en"}, {31'd0, cam_write_enable}, 32'd0);
        chk({nm, " wr_idx"}, {27'd0, cam_write_index}, 32'd0);
        chk({nm, " wr_data"}, cam_write_data, 32'd0);
        chk({nm, " srch_en"}, {31'd0, cam_search_enable}, 32'd0);
        chk({nm, " srch_data"}, cam_search_data, 32'd0);
    endtask

    typedef struct {
        string            nm;
        logic [31:0]      data;
        logic             ins;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             full;
        logic             wr;
        int               lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"ins_first", 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4};
        vecs[1] = '{"ins_dup",   32'hDEADBEEF, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 3};
        vecs[2] = '{"look_miss", 32'h12345678, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3};
        vecs[3] = '{"ins_second",32'h0000A5A5, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 4};
        vecs[4] = '{"look_hit",  32'h0000A5A5, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 3};

        req_if.req_valid_i  = 1'b0;
        req_if.req_data_i   = '0;
        req_if.req_insert_i = 1'b0;
        req_if.rsp_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk_idle("reset");

        foreach (vecs[k])
            run_txn(vecs[k].nm, vecs[k].data, vecs[k].ins, vecs[k].hit, vecs[k].idx,
                    vecs[k].full, vecs[k].wr, vecs[k].lat, 0);

        for (int i = 2; i < DEPTH; i++)
            run_txn("fill", 32'h1000 + i, 1'b1, 1'b0, i[IDX_W-1:0], 1'b0, 1'b1, 4, 0);

`ifdef CAM_LOOKUP_REPLACE_EN
        run_txn("ins_33", 32'h2000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4, 0);
        run_txn("ins_34", 32'h2001, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 4, 0);
`else
        run_txn("ins_33", 32'h2000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 3, 0);
        run_txn("ins_34", 32'h2001, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 3, 0);
`endif
        run_txn("full_dup", 32'h1005, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 3, 0);
        run_txn("hold", 32'h1007, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 3, 10);

        // Reset while the controller waits on the search result.
        @(posedge clk); #1;
        req_if.req_valid_i  = 1'b1;
        req_if.req_data_i   = 32'hBEEF0001;
        req_if.req_insert_i = 1'b1;
        @(posedge clk); #1;
        req_if.req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("wait srch_data", cam_search_data, 32'hBEEF0001);
        chk("wait req_ready", {31'd0, req_if.req_ready_o}, 32'd0);
        rst = 1'b1;
        #1 chk_idle("midrst");
        @(posedge clk); #1 rst = 1'b0;
        run_txn("post_rst", 32'h0000CAFE, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
